// File: rtl/decode_issue_queue.sv
// Decode-to-issue buffer: a small first-word-fall-through FIFO of decoded
// scoreboard entries. Issue is held back after a control-flow instruction
// leaves the queue, until the execute stage reports that it has resolved.

package decode_issue_pkg;

  // Decoded instruction as handed from the decoder to the issue stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;

endpackage

module decode_issue_queue
  import decode_issue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              flush_unissued_instr_i,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_instr_valid_o,
  output logic              is_ctrl_flow_o,
  input  logic              issue_ack_i,
  input  logic              resolve_branch_i,
  output logic              full_o,
  output logic [PTR_W:0]    usage_o
);

  // One buffered slot: the decoded payload plus its control-flow marker.
  typedef struct packed {
    scoreboard_entry_t instr;
    logic              ctrl_flow;
  } slot_t;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   usage_reg, usage_next;
  logic             unresolved_reg, unresolved_next;

  slot_t            slot_q [DEPTH];
  slot_t            head;

  logic             flush_any;
  logic             full;
  logic             pop_ok;
  logic             pop;
  logic             push;

  // Either flush kills this cycle's handshakes; the whole queue is dropped.
  assign flush_any = flush_i | flush_unissued_instr_i;
  assign full      = (usage_reg == DEPTH_CNT);
  assign head      = slot_q[rd_ptr_reg];

  // The head may only leave while no earlier control-flow instruction is
  // still in flight.
  assign pop_ok = (usage_reg != '0) & ~unresolved_reg & ~flush_any;
  assign pop    = issue_ack_i & pop_ok;

  // A full queue still accepts an entry when the head leaves in the same
  // cycle; this is a deliberate combinational path from issue_ack_i.
  // While rst_ni is low nothing is accepted.
  assign push = decoded_instr_valid_i & (~full | pop) & ~flush_any & rst_ni;

  assign decoded_instr_ack_o = push;
  assign issue_instr_valid_o = pop_ok;
  assign issue_instr_o       = head.instr;
  assign is_ctrl_flow_o      = head.ctrl_flow;
  assign full_o              = full;
  assign usage_o             = usage_reg;

  // Slot storage; each slot captures the incoming entry when it is the write target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    slot_t slot_reg;

    // Write the slot on a push addressed to it; reset clears it so the
    // head outputs read as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_reg <= '0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        slot_reg <= '{instr: decoded_instr_i, ctrl_flow: is_ctrl_flow_i};
      end
    end

    assign slot_q[gi] = slot_reg;
  end

  // Next-state for pointers, occupancy and the branch gate.
  always_comb begin
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    usage_next      = usage_reg;
    unresolved_next = unresolved_reg;

    if (flush_any) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      usage_next  = '0;
      // A flush of unissued entries leaves an already issued branch in
      // flight, so the gate is only cleared by a full flush.
      if (flush_i) begin
        unresolved_next = 1'b0;
      end
    end else begin
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        usage_next = usage_reg + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        usage_next = usage_reg - (PTR_W + 1)'(1);
      end

      // A newly issued branch dominates a resolve of the previous one.
      if (pop && head.ctrl_flow) begin
        unresolved_next = 1'b1;
      end else if (resolve_branch_i) begin
        unresolved_next = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      usage_reg      <= '0;
      unresolved_reg <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      usage_reg      <= usage_next;
      unresolved_reg <= unresolved_next;
    end
  end

`ifndef SYNTHESIS
  // Never accept an entry into a full queue unless the head leaves too.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop));

  // Occupancy never exceeds the storage.
  a_usage_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage_reg <= DEPTH_CNT);

  // A presented head that is not taken must not change.
  a_head_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (issue_instr_valid_o && !issue_ack_i) |=> $stable(issue_instr_o));
`endif

endmodule
